// File: rtl/meas_pkg.sv
// Shared types for the period measurement block.
//   mode_e  : edge qualifier encoding carried on the mode input
//   state_e : measurement FSM states
//   edge_hit: mode decode applied to raw rise/fall detections
package meas_pkg;

   typedef enum logic [1:0] {
      MODE_RISE     = 2'd0,
      MODE_FALL     = 2'd1,
      MODE_BOTH     = 2'd2,
      MODE_RISE_ALT = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_STALLED = 2'd0,
      ST_FIRST   = 2'd1,
      ST_RUN     = 2'd2
   } state_e;

   // Encoding 3 behaves as RISE, so it falls into the default arm.
   function automatic logic edge_hit(input mode_e m, input logic rise, input logic fall);
      case (m)
         MODE_FALL: edge_hit = fall;
         MODE_BOTH: edge_hit = rise | fall;
         default:   edge_hit = rise;
      endcase
   endfunction

endpackage

// File: rtl/period_avg_meas_edge_qual.sv
// Edge qualifier: registers sig_in once and flags a qualifying edge in the
// cycle where sig_in differs from its registered copy, filtered by mode.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear (same effect as reset)
//   sig_in     : input signal, already synchronous to clk
//   mode       : edge qualifier (RISE / FALL / BOTH / RISE)
//   qual_edge  : combinational qualified-edge flag
module edge_qual
   import meas_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       sig_in,
   input  logic [1:0] mode,
   output logic       qual_edge
);

   logic sig_q;
   logic sig_d;
   logic rise;
   logic fall;

   always_comb begin
      sig_d = clr ? 1'b0 : sig_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_d;
      end
   end

   always_comb begin
      rise      = sig_in & ~sig_q;
      fall      = ~sig_in & sig_q;
      qual_edge = edge_hit(mode_e'(mode), rise, fall);
   end

endmodule

// File: rtl/period_avg_meas.sv
// Period meter with moving average.
// Counts clk cycles between qualified edges of sig_in, averages the last
// 2^AVG_LOG periods and reports a slice of that average.
//   clk, rst   : clock, asynchronous active-high reset
//   sig_in     : measured signal (synchronous to clk)
//   mode       : edge qualifier, 0=RISE 1=FALL 2=BOTH 3=RISE
//   clr        : synchronous clear, same effect as reset, highest priority
//   period     : averaged period, bits [OUT_LSB +: OUT_W] of sum>>AVG_LOG
//   period_vld : one-cycle pulse when period updates from the average
//   stalled    : no qualifying edge within TIMEOUT cycles
//   avg_ready  : averaging window is full
module period_avg_meas
   import meas_pkg::*;
#(
   parameter int unsigned      CNT_W   = 24,
   parameter logic [CNT_W-1:0] TIMEOUT = 24'hE4E1C0,
   parameter int unsigned      OUT_W   = 8,
   parameter int unsigned      OUT_LSB = CNT_W - OUT_W,
   parameter int unsigned      AVG_LOG = 2
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic [1:0]       mode,
   input  logic             clr,
   output logic [OUT_W-1:0] period,
   output logic             period_vld,
   output logic             stalled,
   output logic             avg_ready
);

   localparam int unsigned DEPTH = 1 << AVG_LOG;
   localparam int unsigned SUM_W = CNT_W + AVG_LOG;
   localparam logic [AVG_LOG:0]   FILL_FULL  = (AVG_LOG+1)'(DEPTH);
   localparam logic [OUT_W-1:0]   PERIOD_RST = OUT_W'(TIMEOUT >> OUT_LSB);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  win_q [DEPTH];
   logic [CNT_W-1:0]  win_d [DEPTH];
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [AVG_LOG:0]  fill_q, fill_d;
   logic [OUT_W-1:0]  period_q, period_d;
   logic              vld_q, vld_d;
   logic              stalled_q, stalled_d;

   logic              qual_edge;
   logic              at_limit;
   logic              push;
   logic              flush;
   logic              stall_entry;
   logic [CNT_W-1:0]  sample;

   edge_qual u_edge_qual (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .sig_in    (sig_in),
      .mode      (mode),
      .qual_edge (qual_edge)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_STALLED;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and event decode
   always_comb begin
      at_limit    = (cnt_q == TIMEOUT);
      state_d     = state_q;
      push        = 1'b0;
      flush       = 1'b0;
      stall_entry = 1'b0;
      case (state_q)
         ST_STALLED: begin
            if (qual_edge) state_d = ST_FIRST;
         end
         ST_FIRST, ST_RUN: begin
            if (qual_edge && at_limit) begin
               // Edge landing on the timeout cycle restarts measurement.
               state_d = ST_FIRST;
               flush   = 1'b1;
            end else if (qual_edge) begin
               state_d = ST_RUN;
               push    = (state_q == ST_FIRST) || (state_q == ST_RUN);
            end else if (at_limit) begin
               state_d     = ST_STALLED;
               flush       = 1'b1;
               stall_entry = 1'b1;
            end
         end
         default: state_d = ST_STALLED;
      endcase
      if (clr) begin
         state_d     = ST_STALLED;
         push        = 1'b0;
         flush       = 1'b0;
         stall_entry = 1'b0;
      end
   end

   // Datapath / outputs
   always_comb begin
      sample    = cnt_q + CNT_ONE;
      cnt_d     = qual_edge ? '0 : (at_limit ? cnt_q : sample);
      win_d     = win_q;
      sum_d     = sum_q;
      fill_d    = fill_q;
      period_d  = period_q;
      vld_d     = 1'b0;
      stalled_d = (state_d == ST_STALLED);

      if (push) begin
         win_d[0] = sample;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            win_d[i] = win_q[i-1];
         end
         // Slots beyond the fill level are zero, so the oldest slot can
         // always be subtracted without checking the fill level.
         sum_d = sum_q + SUM_W'(sample) - SUM_W'(win_q[DEPTH-1]);
         if (fill_q != FILL_FULL) fill_d = fill_q + (AVG_LOG+1)'(1);
         if (fill_d == FILL_FULL) begin
            period_d = OUT_W'(sum_d >> (AVG_LOG + OUT_LSB));
            vld_d    = 1'b1;
         end
      end

      if (flush) begin
         win_d  = '{default: '0};
         sum_d  = '0;
         fill_d = '0;
      end

      if (stall_entry) period_d = PERIOD_RST;

      if (clr) begin
         cnt_d     = '0;
         win_d     = '{default: '0};
         sum_d     = '0;
         fill_d    = '0;
         period_d  = PERIOD_RST;
         vld_d     = 1'b0;
         stalled_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         win_q     <= '{default: '0};
         sum_q     <= '0;
         fill_q    <= '0;
         period_q  <= PERIOD_RST;
         vld_q     <= 1'b0;
         stalled_q <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         win_q     <= win_d;
         sum_q     <= sum_d;
         fill_q    <= fill_d;
         period_q  <= period_d;
         vld_q     <= vld_d;
         stalled_q <= stalled_d;
      end
   end

   assign period     = period_q;
   assign period_vld = vld_q;
   assign stalled    = stalled_q;
   assign avg_ready  = (fill_q == FILL_FULL);

endmodule

// File: tb/tb_period_avg_meas.sv
// Directed bench for period_avg_meas with CNT_W=16, TIMEOUT=1000,
// OUT_W=16, OUT_LSB=0, AVG_LOG=2.
module tb_period_avg_meas;

   logic        clk = 1'b0;
   logic        rst;
   logic        sig_in;
   logic [1:0]  mode;
   logic        clr;
   logic [15:0] period;
   logic        period_vld;
   logic        stalled;
   logic        avg_ready;

   int   checks   = 0;
   int   failures = 0;
   int   vld_cnt  = 0;
   int   vld_base = 0;
   logic first_vld;

   always #5 clk = ~clk;

   period_avg_meas #(
      .CNT_W   (16),
      .TIMEOUT (16'd1000),
      .OUT_W   (16),
      .OUT_LSB (0),
      .AVG_LOG (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sig_in     (sig_in),
      .mode       (mode),
      .clr        (clr),
      .period     (period),
      .period_vld (period_vld),
      .stalled    (stalled),
      .avg_ready  (avg_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (period_vld === 1'b1) vld_cnt++;
   endtask

   // Rising edge, then low for the second half; next call's edge lands gap cycles later.
   task automatic rise(input int gap);
      sig_in = 1'b1;
      tick();
      first_vld = period_vld;
      repeat (gap/2 - 1) tick();
      sig_in = 1'b0;
      repeat (gap - gap/2) tick();
   endtask

   task automatic toggle(input int gap);
      sig_in = ~sig_in;
      tick();
      first_vld = period_vld;
      repeat (gap - 1) tick();
   endtask

   initial begin
      rst    = 1'b1;
      sig_in = 1'b0;
      clr    = 1'b0;
      mode   = 2'd0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_stalled",   stalled,    1);
      chk("rst_period",    period,     1000);
      chk("rst_avg_ready", avg_ready,  0);
      chk("rst_vld",       period_vld, 0);

      // RISE mode, 100-cycle spacing
      vld_base = vld_cnt;
      repeat (4) rise(100);
      chk("rise_no_early_vld", vld_cnt - vld_base, 0);
      chk("rise_period_hold",  period, 1000);
      chk("rise_not_ready",    avg_ready, 0);
      rise(200);
      chk("rise5_vld_next",  first_vld, 1);
      chk("rise5_one_vld",   vld_cnt - vld_base, 1);
      chk("rise5_period",    period, 100);
      chk("rise5_avg_ready", avg_ready, 1);
      chk("rise5_stalled",   stalled, 0);
      rise(200);
      chk("rise6_vld",    first_vld, 1);
      chk("rise6_period", period, 125);
      chk("rise6_count",  vld_cnt - vld_base, 2);
      sig_in = 1'b1;
      tick();
      chk("rise7_vld",    period_vld, 1);
      chk("rise7_period", period, 150);

      // Hold high until timeout
      vld_base = vld_cnt;
      repeat (1000) tick();
      chk("pre_timeout_stalled", stalled, 0);
      tick();
      chk("timeout_stalled",   stalled, 1);
      chk("timeout_period",    period, 1000);
      chk("timeout_avg_ready", avg_ready, 0);
      chk("timeout_no_vld",    vld_cnt - vld_base, 0);

      // Recovery after stall
      sig_in = 1'b0;
      repeat (50) tick();
      vld_base = vld_cnt;
      repeat (5) rise(100);
      chk("recover_vld",     first_vld, 1);
      chk("recover_count",   vld_cnt - vld_base, 1);
      chk("recover_period",  period, 100);
      chk("recover_stalled", stalled, 0);

      // Clear mid-RUN
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_stalled",   stalled, 1);
      chk("clr_period",    period, 1000);
      chk("clr_avg_ready", avg_ready, 0);
      chk("clr_vld",       period_vld, 0);

      // BOTH mode, 200-cycle square wave
      mode = 2'd2;
      vld_base = vld_cnt;
      repeat (4) toggle(100);
      chk("both_no_early_vld", vld_cnt - vld_base, 0);
      chk("both_period_hold",  period, 1000);
      toggle(1001);
      chk("both_vld",       first_vld, 1);
      chk("both_period",    period, 100);
      chk("both_avg_ready", avg_ready, 1);
      chk("coinc_pre_stalled", stalled, 0);

      // Edge on the same cycle the counter hits TIMEOUT
      vld_base = vld_cnt;
      sig_in = ~sig_in;
      tick();
      chk("coinc_stalled",   stalled, 0);
      chk("coinc_vld",       period_vld, 0);
      chk("coinc_avg_ready", avg_ready, 0);
      repeat (99) tick();
      repeat (3) toggle(100);
      chk("coinc_refill_no_vld", vld_cnt - vld_base, 0);
      chk("coinc_refill_ready",  avg_ready, 0);
      toggle(100);
      chk("coinc_full_vld",    first_vld, 1);
      chk("coinc_full_period", period, 100);
      chk("coinc_full_ready",  avg_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/period_avg_meas.md
PERIOD_AVG_MEAS -- requirements
Module: period_avg_meas

Interface
REQ-001 SHALL have parameter CNT_W, default 24: width of the period counter in bits.
REQ-002 SHALL have parameter TIMEOUT, default 24'hE4E1C0: cycle count at which the input is declared stalled.
REQ-003 SHALL have parameter OUT_W, default 8: width of the reported period.
REQ-004 SHALL have parameter OUT_LSB, default CNT_W-OUT_W: lowest bit of the averaged period that appears on the output.
REQ-005 SHALL have parameter AVG_LOG, default 2: log2 of the moving-average window depth (1..4).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port sig_in, input, 1 bit: filtered signal, already synchronous to clk.
REQ-009 SHALL have port mode, input, 2 bits: edge qualifier, 0=RISE, 1=FALL, 2=BOTH, 3=RISE.
REQ-010 SHALL have port clr, input, 1 bit: synchronous clear with the same effect as reset.
REQ-011 SHALL have port period, output, OUT_W bits: averaged period slice.
REQ-012 SHALL have port period_vld, output, 1 bit: one-cycle pulse when period updates.
REQ-013 SHALL have port stalled, output, 1 bit: no qualifying edge has arrived within TIMEOUT cycles.
REQ-014 SHALL have port avg_ready, output, 1 bit: the averaging window is full.

Function
REQ-015 SHALL register sig_in once; an edge is qualified in cycle t, per mode, when sig_in differs from its registered copy.
REQ-016 SHALL run a CNT_W counter that clears to 0 on a qualified edge, otherwise increments, and saturates at TIMEOUT.
REQ-017 SHALL implement FSM STALLED / FIRST / RUN.
- STALLED, on edge: go to FIRST and clear the counter.
- FIRST, on edge with count<TIMEOUT: push sample (count+1) and go to RUN.
- FIRST or RUN, on count==TIMEOUT with no edge: go to STALLED.
- RUN, on edge: push sample (count+1).
REQ-018 SHALL treat an edge in the same cycle as count==TIMEOUT as a first edge: flush the window and go to FIRST; no sample is pushed.
REQ-019 SHALL hold the last 2^AVG_LOG samples in a FIFO-ordered window with a running sum; each push adds the new sample and, once the window is full, subtracts the oldest.
REQ-020 SHALL size the running sum to CNT_W+AVG_LOG bits so that no overflow can occur.
REQ-021 SHALL assert avg_ready once 2^AVG_LOG samples are held, and clear it on a flush.
REQ-022 SHALL, on each push made while the window is full (including the filling push), register (sum>>AVG_LOG)[OUT_LSB+:OUT_W] to period and pulse period_vld in cycle t+1.
REQ-023 SHALL drive stalled high in STALLED and low otherwise; it updates in the cycle after the FSM changes state.
REQ-024 SHALL, on entry to STALLED, flush the window, clear avg_ready, and load period with TIMEOUT[OUT_LSB+:OUT_W] without pulsing period_vld.
REQ-025 SHALL keep period unchanged while in FIRST or RUN until the window is full.
REQ-026 SHALL apply a mode change from the next qualified edge, without flushing the window.
REQ-027 SHALL give clr priority over edge and timeout events.

Reset
REQ-028 SHALL, while rst is asserted, set the FSM to STALLED, the counter to 0, the window and sum to 0, period to TIMEOUT[OUT_LSB+:OUT_W], period_vld to 0, stalled to 1, avg_ready to 0, and the registered sig_in to 0.
REQ-029 SHALL apply reset asserted mid-measurement immediately, with no partial average emitted.

Structure
REQ-030 SHALL place the mode encoding typedef and the FSM state typedef in package meas_pkg.
REQ-031 SHALL implement edge qualification (the sig_in register plus the mode decode) as sub-module edge_qual.

Verification
Bench parameters: CNT_W=16, TIMEOUT=1000, OUT_W=16, OUT_LSB=0, AVG_LOG=2.
REQ-032 Reset, then release with sig_in=0 -> stalled=1, period=1000, avg_ready=0, period_vld=0.
REQ-033 mode=RISE, 5 rising edges spaced 100 cycles -> exactly one period_vld, one cycle after the 5th edge; period=100; avg_ready=1; stalled=0.
REQ-034 Continue with edge spacings 200 then 200 -> period=125, then period=150, with one period_vld pulse each.
REQ-035 Hold sig_in constant for 1000 cycles after the last edge -> stalled=1, period=1000, avg_ready=0, no period_vld; the next 5 edges spaced 100 cycles restore period=100.
REQ-036 mode=BOTH, square wave with a 200-cycle period -> period=100 after 5 edges.
REQ-037 Edge coincident with count==1000 -> FSM goes to FIRST, no sample pushed, stalled=0 next cycle; clr asserted mid-RUN -> reset values (REQ-028) on the next cycle.
